// File: rtl/svlib_skid_pkg.sv
// svlib_skid_pkg: shared state encoding and occupancy width for the skid buffer
package svlib_skid_pkg;
    localparam int SKID_CNT_W = 2;
    typedef enum logic [SKID_CNT_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;
endpackage

// File: rtl/register_en_sync_rst.sv
// register_en_sync_rst: enable register with active-high synchronous reset
//   clk  - clock
//   rst  - synchronous reset, loads RESET_VAL
//   en   - load enable
//   din  - next value
//   dout - registered value
module register_en_sync_rst #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk) begin
        if (rst) data_q <= RESET_VAL;
        else if (en) data_q <= din;
    end
    assign dout = data_q;
endmodule

// File: rtl/skid_buffer_flush_sync_rst.sv
// skid_buffer_flush_sync_rst: two-entry valid/ready skid buffer with synchronous flush
//   clk, rst         - clock, synchronous active-high reset
//   flush            - kills all buffered entries
//   s_valid/s_ready  - upstream handshake, s_data payload
//   m_valid/m_ready  - downstream handshake, m_data payload (main entry)
//   count            - occupancy 0..2
module skid_buffer_flush_sync_rst
    import svlib_skid_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic [SKID_CNT_W-1:0] count
);
    skid_state_t      state_q, state_d;
    logic             main_en, skid_en, s_fire, m_fire;
    logic [WIDTH-1:0] main_d, skid_d, skid_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else state_q <= state_d;
    end

    // Outputs depend only on registered state plus rst/flush gating.
    always_comb begin
        s_ready = !rst && !flush && state_q != FULL;
        m_valid = !rst && !flush && state_q != EMPTY;
        count   = rst ? '0 : state_q;
        s_fire  = s_valid && s_ready;
        m_fire  = m_valid && m_ready;
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b1;
            skid_en = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    state_d = s_fire ? ONE : EMPTY;
                    main_en = s_fire;
                end
                ONE: begin
                    state_d = s_fire ? (m_fire ? ONE : FULL) : (m_fire ? EMPTY : ONE);
                    main_en = s_fire && m_fire;
                    skid_en = s_fire && !m_fire;
                end
                FULL: begin
                    state_d = m_fire ? ONE : FULL;
                    main_en = m_fire;
                end
                default: state_d = EMPTY;
            endcase
        end
        // Flush zeroes both entries; FULL drains skid into main.
        main_d = flush ? '0 : (state_q == FULL ? skid_q : s_data);
        skid_d = flush ? '0 : s_data;
    end

    register_en_sync_rst #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk(clk), .rst(rst), .en(main_en), .din(main_d), .dout(m_data)
    );

    register_en_sync_rst #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk(clk), .rst(rst), .en(skid_en), .din(skid_d), .dout(skid_q)
    );
endmodule

// File: tb/tb_skid_buffer_flush_sync_rst.sv
// tb_skid_buffer_flush_sync_rst: vector table, stall sequence and random run against a queue model
module tb_skid_buffer_flush_sync_rst;
    logic       clk = 1'b0;
    logic       rst = 1'b1, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready, m_valid;
    logic [7:0] m_data;
    logic [1:0] count;
    int         n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    skid_buffer_flush_sync_rst #(.WIDTH(8), .RESET_VAL(8'h3C)) dut (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count)
    );

    typedef struct {
        logic       r, f, sv;
        logic [7:0] sd;
        logic       mr, esr, emv;
        logic [1:0] ecnt;
        logic       cd;
        logic [7:0] ed;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] q[$];
    logic [7:0] got[$];

    function automatic vec_t mk(logic r, logic f, logic sv, logic [7:0] sd, logic mr,
                                logic esr, logic emv, logic [1:0] ecnt, logic cd, logic [7:0] ed);
        vec_t v;
        v.r = r; v.f = f; v.sv = sv; v.sd = sd; v.mr = mr;
        v.esr = esr; v.emv = emv; v.ecnt = ecnt; v.cd = cd; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Inputs driven after the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic r, input logic f, input logic sv, input logic [7:0] sd, input logic mr);
        rst = r; flush = f; s_valid = sv; s_data = sd; m_ready = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Queue model: outputs from occupancy, updates from the handshake rules.
    task automatic model_check(input string tag);
        logic sr_m, mv_m;
        sr_m = !rst && !flush && q.size() < 2;
        mv_m = !rst && !flush && q.size() > 0;
        chk({tag, "_s_ready"}, {7'd0, s_ready}, {7'd0, sr_m});
        chk({tag, "_m_valid"}, {7'd0, m_valid}, {7'd0, mv_m});
        chk({tag, "_count"}, {6'd0, count}, rst ? 8'd0 : 8'(q.size()));
        if (mv_m) chk({tag, "_m_data"}, m_data, q[0]);
    endtask

    task automatic model_step();
        logic sr_m, mv_m;
        sr_m = !rst && !flush && q.size() < 2;
        mv_m = !rst && !flush && q.size() > 0;
        if (rst || flush) q.delete();
        else begin
            if (mv_m && m_ready) void'(q.pop_front());
            if (s_valid && sr_m) q.push_back(s_data);
        end
    endtask

    initial begin
        // r f sv sd mr | s_ready m_valid count chk_data data
        tbl.push_back(mk(1,0,0,8'h00,0, 0,0,0, 0,8'h00));
        tbl.push_back(mk(1,0,0,8'h00,0, 0,0,0, 0,8'h00));
        tbl.push_back(mk(0,0,1,8'h11,1, 1,0,0, 1,8'h3C));
        tbl.push_back(mk(0,0,1,8'h22,1, 1,1,1, 1,8'h11));
        tbl.push_back(mk(0,0,1,8'h33,1, 1,1,1, 1,8'h22));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1, 1,8'h33));
        tbl.push_back(mk(0,0,1,8'hA0,0, 1,0,0, 1,8'h33));
        tbl.push_back(mk(0,0,1,8'hA1,0, 1,1,1, 1,8'hA0));
        tbl.push_back(mk(0,0,1,8'hA2,0, 0,1,2, 1,8'hA0));
        tbl.push_back(mk(0,0,0,8'h00,1, 0,1,2, 1,8'hA0));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1, 1,8'hA1));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,0,0, 0,8'h00));
        tbl.push_back(mk(0,0,1,8'h5A,0, 1,0,0, 0,8'h00));
        tbl.push_back(mk(0,0,1,8'h5B,0, 1,1,1, 1,8'h5A));
        tbl.push_back(mk(0,0,0,8'h00,0, 0,1,2, 1,8'h5A));
        tbl.push_back(mk(0,1,1,8'h66,1, 0,0,2, 0,8'h00));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,0,0, 1,8'h00));
        tbl.push_back(mk(0,0,1,8'h77,1, 1,0,0, 0,8'h00));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1, 1,8'h77));
        tbl.push_back(mk(0,0,1,8'h88,0, 1,0,0, 0,8'h00));
        tbl.push_back(mk(1,1,1,8'h99,1, 0,0,0, 0,8'h00));
        tbl.push_back(mk(0,0,1,8'h01,0, 1,0,0, 1,8'h3C));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1, 1,8'h01));
        tbl.push_back(mk(0,0,1,8'hC1,0, 1,0,0, 0,8'h00));
        tbl.push_back(mk(0,1,1,8'hC2,1, 0,0,1, 0,8'h00));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,0,0, 1,8'h00));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,0,0, 0,8'h00));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].sv, tbl[i].sd, tbl[i].mr);
            chk($sformatf("vec%0d_s_ready", i), {7'd0, s_ready}, {7'd0, tbl[i].esr});
            chk($sformatf("vec%0d_m_valid", i), {7'd0, m_valid}, {7'd0, tbl[i].emv});
            chk($sformatf("vec%0d_count", i), {6'd0, count}, {6'd0, tbl[i].ecnt});
            if (tbl[i].cd) chk($sformatf("vec%0d_m_data", i), m_data, tbl[i].ed);
            tick();
        end

        // Full-rate push of 0..7 with m_ready low in cycles 3 and 4.
        begin
            int nxt = 0;
            for (int c = 0; c < 40 && got.size() < 8; c++) begin
                drive(0, 0, nxt < 8, 8'(nxt), !(c == 3 || c == 4));
                if (m_valid && m_ready) got.push_back(m_data);
                if (s_valid && s_ready) nxt++;
                tick();
            end
            chk("stall_delivered", 8'(got.size()), 8'd8);
            foreach (got[i]) chk($sformatf("stall_word%0d", i), got[i], 8'(i));
        end

        // Randomized run against the queue model.
        drive(1, 0, 0, 8'h00, 0);
        tick();
        q.delete();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
                  1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);
            model_check($sformatf("rnd%0d", c));
            model_step();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/skid_buffer_flush_sync_rst.md
# skid_buffer_flush_sync_rst

Two-entry valid/ready skid buffer with synchronous flush, used as the handshake stage that feeds a pipeline's enable/flush data registers. It breaks the combinational `ready` path: `s_ready` is a pure function of registered state. Throughput is one transfer per cycle, with a fixed 1-cycle latency. A flush drops all buffered data in the same cycle, matching the kill semantics of the downstream flush registers.

## Interface
Parameters:
- `WIDTH`, default 1: payload width in bits.
- `RESET_VAL`, default '0: value loaded into both data entries on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `flush`  in  1  synchronous kill of all buffered entries.
- `s_valid`  in  1  upstream payload valid.
- `s_ready`  out  1  buffer can accept; registered-state-derived, never depends on `m_ready`.
- `s_data`  in  WIDTH  upstream payload.
- `m_valid`  out  1  downstream payload valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  WIDTH  downstream payload; always driven from the main entry register.
- `count`  out  2  occupancy: 0, 1 or 2.

## Operation
- Handshake events:
  - `s_fire = s_valid & s_ready`
  - `m_fire = m_valid & m_ready`
- Storage: main entry (drives `m_data`) and skid entry. State is EMPTY, ONE or FULL.
- Output decode:
  - EMPTY: `s_ready`=1, `m_valid`=0, `count`=0.
  - ONE: `s_ready`=1, `m_valid`=1, `count`=1.
  - FULL: `s_ready`=0, `m_valid`=1, `count`=2.
- Transitions when `rst`=0 and `flush`=0:
  - EMPTY, `s_fire` → ONE; main ← `s_data`.
  - ONE, `s_fire & m_fire` → ONE; main ← `s_data`.
  - ONE, `s_fire & !m_ready` → FULL; skid ← `s_data`.
  - ONE, `!s_fire & m_fire` → EMPTY.
  - FULL, `m_fire` → ONE; main ← skid.
  - Otherwise: hold.
- Flush (`flush`=1, `rst`=0):
  - Combinationally forces `m_valid`=0 and `s_ready`=0, so no handshake completes in a flush cycle.
  - At the edge: state → EMPTY, main ← 0, skid ← 0.
- Reset (`rst`=1):
  - Combinationally forces `s_ready`=0, `m_valid`=0, `count`=0.
  - At the edge: state → EMPTY, main ← `RESET_VAL`, skid ← `RESET_VAL`.
  - Reset overrides flush.
- Priority: `rst` > `flush` > handshake.
- Data never reorders or duplicates. When `m_valid`=0, `m_data` holds its last value and must be ignored.
- Reset or flush asserted mid-stream discards all entries; the first accepted word afterwards is the first word delivered.

## Timing
- Latency: a word accepted at edge N is presented on `m_data`/`m_valid` in the cycle after edge N.
- Throughput: one word per cycle sustained while `m_ready`=1; no bubbles.
- Backpressure: if `m_ready` drops while a word is in flight, one extra word is absorbed into the skid entry. `s_ready` deasserts in the cycle after that edge (state FULL).
- FULL with `m_fire` returns to ONE. `s_ready` reasserts the next cycle, so there is a one-cycle bubble on the upstream side only.
- First cycle after `rst` deasserts: `s_ready`=1, `m_valid`=0.
- All outputs settle from registers plus the `rst`/`flush` gating only. There is no `s_valid`→`s_ready` or `m_ready`→`s_ready` combinational path.

## Structure
- Shared package `svlib_skid_pkg`:
  - `skid_state_t` (EMPTY=2'd0, ONE=2'd1, FULL=2'd2)
  - occupancy width constant `SKID_CNT_W`=2
- Sub-module: `register_en_sync_rst` (enable register, active-high synchronous reset), instantiated for the main and skid entries.
  - Enables come from the transition logic.
  - Flush-zeroing is muxed onto `din`.
- State register and `count` are in-module: `count` decodes directly from state.

## Test plan
- Reset then stream: assert `rst` for 2 cycles. Push 0x11, 0x22, 0x33 with `m_ready`=1 → `m_data` shows 0x11, 0x22, 0x33 on consecutive cycles, one cycle after each accept; `count` stays 1.
- Backpressure fill: push 0xA0, 0xA1 while `m_ready`=0 → `count`=2 and `s_ready`=0. Release `m_ready` → 0xA0, then 0xA1 delivered; `count` goes 2→1→0.
- Full-rate with stall: continuous push of 0..7, deasserting `m_ready` for cycles 3–4 → all 8 words delivered in order, none lost or duplicated.
- Flush while FULL: hold state FULL (0x5A main, 0x5B skid), then assert `flush` for 1 cycle → `m_valid`=0 and `s_ready`=0 that cycle. Next cycle: `count`=0, `s_ready`=1. Next pushed 0x77 is the first word delivered.
- Reset beats flush: assert `rst` and `flush` together while state ONE with `RESET_VAL`=0x3C → next cycle state is EMPTY. After the first accept of 0x01, `m_data`=0x01.
- Flush with simultaneous `s_valid` and `m_ready`: no `s_fire` or `m_fire` occurs; the word offered that cycle is not stored.
